// File: rtl/bnw_pkg.sv
// bnw_pkg: shared constants, lane-state enum and helpers for the hit judge.
// No ports; imported by lane_judge, hit_judge and the interface users.
package bnw_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    LIVE = 2'd1,
    DONE = 2'd2
  } lane_st_e;

  localparam int NUM_LANES   = 4;
  localparam int OFFSCREEN_H = 720;
  localparam int SPAWN_H     = 120;

  localparam int ZONE_LO_D    = 560;
  localparam int PERFECT_LO_D = 600;
  localparam int PERFECT_HI_D = 640;
  localparam int ZONE_HI_D    = 680;
  localparam int MISS_LIMIT_D = 5;
  localparam int SCORE_MAX_D  = 999;
  localparam int COMBO_MAX    = 99;

  function automatic logic [2:0] popcnt4(
    input logic [3:0] v
  );
    return {2'b0, v[0]} + {2'b0, v[1]}
         + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

endpackage

// File: rtl/hit_judge_if.sv
// hit_judge_if: game-side inputs (freeze, heights, keys) and score outputs.
// master drives heights/keys and reads results; slave is the judge.
interface hit_judge_if;
  logic        stop_or_endgame;
  logic [39:0] block_h;
  logic [3:0]  key_press;
  logic [9:0]  score;
  logic [6:0]  combo;
  logic [3:0]  miss_cnt;
  logic        game_over;
  logic [3:0]  hit_pulse;
  logic        perfect_pulse;
  logic [3:0]  miss_pulse;

  modport master (
    output stop_or_endgame, block_h, key_press,
    input  score, combo, miss_cnt, game_over,
    input  hit_pulse, perfect_pulse, miss_pulse
  );

  modport slave (
    input  stop_or_endgame, block_h, key_press,
    output score, combo, miss_cnt, game_over,
    output hit_pulse, perfect_pulse, miss_pulse
  );
endinterface

// File: rtl/hit_judge_lane.sv
// lane_judge: per-lane key edge detector and WAIT/LIVE/DONE judging FSM.
// Ports: clk, i_arst, i_en, i_h, i_key in; o_hit/o_perfect/o_miss strobes.
module lane_judge
  import bnw_pkg::*;
#(
  parameter int ZONE_LO    = ZONE_LO_D,
  parameter int PERFECT_LO = PERFECT_LO_D,
  parameter int PERFECT_HI = PERFECT_HI_D,
  parameter int ZONE_HI    = ZONE_HI_D
) (
  input  logic       clk,
  input  logic       i_arst,
  input  logic       i_en,
  input  logic [9:0] i_h,
  input  logic       i_key,
  output logic       o_hit,
  output logic       o_perfect,
  output logic       o_miss
);

  localparam logic [9:0] ZLO = 10'(ZONE_LO);
  localparam logic [9:0] ZHI = 10'(ZONE_HI);
  localparam logic [9:0] PLO = 10'(PERFECT_LO);
  localparam logic [9:0] PHI = 10'(PERFECT_HI);

  lane_st_e r_st;
  lane_st_e w_st_nxt;
  logic     r_key_q;
  logic     w_press;
  logic     w_below;
  logic     w_above;
  logic     w_in_zone;
  logic     w_perf_win;

  assign w_press    = i_key & ~r_key_q;
  assign w_below    = i_h < ZLO;
  assign w_above    = i_h >= ZHI;
  assign w_in_zone  = ~w_below & ~w_above;
  assign w_perf_win = (i_h >= PLO) && (i_h < PHI);

  // A block entering the zone on the same tick as a
  // press is judged as live, not as a stray press.
  always_comb begin
    w_st_nxt  = r_st;
    o_hit     = 1'b0;
    o_miss    = 1'b0;
    if (i_en) begin
      unique case (r_st)
        WAIT: begin
          if (w_in_zone) begin
            if (w_press) begin
              o_hit    = 1'b1;
              w_st_nxt = DONE;
            end else begin
              w_st_nxt = LIVE;
            end
          end else if (w_press) begin
            o_miss = 1'b1;
          end
        end
        LIVE: begin
          if (w_below) begin
            o_miss   = 1'b1;
            w_st_nxt = WAIT;
          end else if (w_above) begin
            o_miss   = 1'b1;
            w_st_nxt = DONE;
          end else if (w_press) begin
            o_hit    = 1'b1;
            w_st_nxt = DONE;
          end
        end
        DONE: begin
          if (w_below) w_st_nxt = WAIT;
        end
        default: w_st_nxt = WAIT;
      endcase
    end
  end

  assign o_perfect = o_hit & w_perf_win;

  // key_q tracks the key even when frozen so a held
  // key cannot fire on resume.
  always_ff @(posedge clk or posedge i_arst) begin
    if (i_arst) begin
      r_st    <= WAIT;
      r_key_q <= 1'b0;
    end else begin
      r_st    <= w_st_nxt;
      r_key_q <= i_key;
    end
  end

endmodule

// File: rtl/hit_judge.sv
// hit_judge: four lane judges plus score/combo/miss accumulation, game_over.
// Ports: clk, rst, restart (async resets) and bus (hit_judge_if.slave).
module hit_judge
  import bnw_pkg::*;
#(
  parameter int ZONE_LO    = ZONE_LO_D,
  parameter int PERFECT_LO = PERFECT_LO_D,
  parameter int PERFECT_HI = PERFECT_HI_D,
  parameter int ZONE_HI    = ZONE_HI_D,
  parameter int MISS_LIMIT = MISS_LIMIT_D,
  parameter int SCORE_MAX  = SCORE_MAX_D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  hit_judge_if.slave  bus
);

  localparam logic [10:0] SMAX11 = 11'(SCORE_MAX);
  localparam logic [9:0]  SMAX10 = 10'(SCORE_MAX);
  localparam logic [7:0]  CMAX8  = 8'(COMBO_MAX);
  localparam logic [6:0]  CMAX7  = 7'(COMBO_MAX);
  localparam logic [4:0]  MLIM5  = 5'(MISS_LIMIT);
  localparam logic [3:0]  MLIM4  = 4'(MISS_LIMIT);

  logic        w_arst;
  logic        w_en;
  logic [3:0]  w_hit;
  logic [3:0]  w_perf;
  logic [3:0]  w_miss;
  logic [2:0]  w_n_hit;
  logic [2:0]  w_n_perf;
  logic [2:0]  w_n_miss;
  logic [10:0] w_score_sum;
  logic [7:0]  w_combo_sum;
  logic [4:0]  w_miss_sum;
  logic [9:0]  w_score_nxt;
  logic [6:0]  w_combo_nxt;
  logic [3:0]  w_miss_nxt;

  logic [9:0]  r_score;
  logic [6:0]  r_combo;
  logic [3:0]  r_miss_cnt;
  logic        r_game_over;
  logic [3:0]  r_hit_pulse;
  logic        r_perf_pulse;
  logic [3:0]  r_miss_pulse;

  assign w_arst = rst | restart;
  assign w_en   = ~bus.stop_or_endgame & ~r_game_over;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_judge #(
      .ZONE_LO    (ZONE_LO),
      .PERFECT_LO (PERFECT_LO),
      .PERFECT_HI (PERFECT_HI),
      .ZONE_HI    (ZONE_HI)
    ) u_lj (
      .clk       (clk),
      .i_arst    (w_arst),
      .i_en      (w_en),
      .i_h       (bus.block_h[10*g +: 10]),
      .i_key     (bus.key_press[g]),
      .o_hit     (w_hit[g]),
      .o_perfect (w_perf[g]),
      .o_miss    (w_miss[g])
    );
  end

  assign w_n_hit  = popcnt4(w_hit);
  assign w_n_perf = popcnt4(w_perf);
  assign w_n_miss = popcnt4(w_miss);

  // Perfect is worth 2, good 1: hits + perfects.
  assign w_score_sum = {1'b0, r_score}
                     + {8'b0, w_n_hit}
                     + {8'b0, w_n_perf};
  assign w_combo_sum = {1'b0, r_combo}
                     + {5'b0, w_n_hit};
  assign w_miss_sum  = {1'b0, r_miss_cnt}
                     + {2'b0, w_n_miss};

  always_comb begin
    w_score_nxt = w_score_sum[9:0];
    if (w_score_sum > SMAX11) w_score_nxt = SMAX10;
    w_combo_nxt = w_combo_sum[6:0];
    if (w_combo_sum > CMAX8) w_combo_nxt = CMAX7;
    if (|w_miss) w_combo_nxt = '0;
    w_miss_nxt = w_miss_sum[3:0];
    if (w_miss_sum >= MLIM5) w_miss_nxt = MLIM4;
  end

  always_ff @(posedge clk or posedge w_arst) begin
    if (w_arst) begin
      r_score      <= '0;
      r_combo      <= '0;
      r_miss_cnt   <= '0;
      r_game_over  <= 1'b0;
      r_hit_pulse  <= '0;
      r_perf_pulse <= 1'b0;
      r_miss_pulse <= '0;
    end else begin
      r_hit_pulse  <= w_en ? w_hit : '0;
      r_perf_pulse <= w_en & (|w_perf);
      r_miss_pulse <= w_en ? w_miss : '0;
      if (w_en) begin
        r_score     <= w_score_nxt;
        r_combo     <= w_combo_nxt;
        r_miss_cnt  <= w_miss_nxt;
        r_game_over <= (w_miss_nxt == MLIM4);
      end
    end
  end

  assign bus.score         = r_score;
  assign bus.combo         = r_combo;
  assign bus.miss_cnt      = r_miss_cnt;
  assign bus.game_over     = r_game_over;
  assign bus.hit_pulse     = r_hit_pulse;
  assign bus.perfect_pulse = r_perf_pulse;
  assign bus.miss_pulse    = r_miss_pulse;

endmodule
